// File: rtl/ps2_frame_rx.sv
// Receive-only PS/2 link layer: synchronises and deglitches the PS/2 lines,
// assembles 11-bit device-to-host frames and reports bytes, prefixes and errors.
module ps2_frame_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       is_extend,
  output logic       is_break,
  output logic       valid,
  output logic       err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

  state_e        state_q, state_d;
  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   shift_q, shift_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [7:0]    key_q, key_d;
  logic          ext_q, ext_d, brk_q, brk_d, valid_q, valid_d, err_q, err_d;
  logic [7:0]    rx_byte;
  logic          frame_ok;

  // Idle PS/2 lines are high, so the synchronisers reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive differing cycle.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign rx_byte  = shift_q[8:1];
  assign frame_ok = (^shift_q[9:1]) & shift_q[10];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tout_d    = tout_q;
    key_d     = key_q;
    ext_d     = 1'b0;
    brk_d     = 1'b0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall && !data_s2_q) begin
          state_d   = StRecv;
          bit_cnt_d = 4'd1;
          shift_d   = 11'd0;
          tout_d    = '0;
        end
      end
      StRecv: begin
        if (fall) begin
          shift_d   = {data_s2_q, shift_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tout_d    = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d = StCheck;
          end
        end else if (tout_q == TW'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          bit_cnt_d = 4'd0;
          tout_d    = '0;
          err_d     = 1'b1;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      StCheck: begin
        state_d   = StIdle;
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          key_d = rx_byte;
          if (rx_byte == 8'hE0) begin
            ext_d = 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            valid_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 11'd0;
      tout_q    <= '0;
      key_q     <= 8'h00;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tout_q    <= tout_d;
      key_q     <= key_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign key_in    = key_q;
  assign is_extend = ext_q;
  assign is_break  = brk_q;
  assign valid     = valid_q;
  assign err       = err_q;

endmodule
